oric_tape_player: RTL

//  Transmit end of the cassette interface: replays a tape image held in

---
 rtl/oric_tape_if.sv | 24 ++
 rtl/oric_tape_player.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/oric_tape_if.sv
// Tape RAM read port plus image length, shared by the cassette player and
// whatever holds the tape image.
interface oric_tape_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] tape_len;
  logic [ADDR_W-1:0] tape_addr;
  logic              tape_rd;
  logic [7:0]        tape_data;

  modport master (
    input  tape_len,
    input  tape_data,
    output tape_addr,
    output tape_rd
  );

  modport slave (
    output tape_len,
    output tape_data,
    input  tape_addr,
    input  tape_rd
  );
endinterface

// File: rtl/oric_tape_player.sv
// Oric cassette playback: serialises tape RAM bytes (start, 8 data LSB first,
// odd parity, stop bits) into the K7_TAPEIN waveform, timed off ENA_1MHZ.
//
// state | meaning
// IDLE  | waiting for a play edge, line low
// FETCH | tape RAM read strobe for the current address
// LOAD  | capture byte, compute parity, restart the cell index
// HIGH  | first half of a cell, line high for T_HALF ticks
// LOW   | line low for T_HALF ('1') or 2*T_HALF ('0') ticks
// DONE  | one-cycle completion pulse
module oric_tape_player #(
  parameter int T_HALF     = 208,
  parameter int ADDR_W     = 16,
  parameter int STOP_BITS  = 3,
  parameter bit MOTOR_GATE = 1'b1
) (
  input  logic        CLK_IN,
  input  logic        RESET,
  input  logic        ENA_1MHZ,
  input  logic        play,
  input  logic        stop,
  input  logic        K7_REMOTE,
  oric_tape_if.master bus,
  output logic        K7_TAPEIN,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_HIGH, S_LOW, S_DONE
  } state_t;

  localparam int CNT_W = $clog2(2 * T_HALF + 1);
  localparam int IDX_W = 5;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(T_HALF);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(2 * T_HALF);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(9 + STOP_BITS);

  state_t            r_state, w_state_nxt;
  logic              r_play_d1, r_play_d2;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic              r_parity, w_parity_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_play_edge, w_run, w_tc, w_bit, w_last_byte;

  assign w_play_edge = r_play_d1 & ~r_play_d2;
  assign w_run       = ENA_1MHZ & (K7_REMOTE | ~MOTOR_GATE);
  assign w_tc        = w_run && (r_cnt == CNT_W'(1));
  assign w_last_byte = (r_addr == bus.tape_len - ADDR_W'(1));

  // Data bits are consumed from r_data[0]; the register shifts after each data cell.
  always_comb begin
    w_bit = 1'b1;
    if (r_idx == '0)
      w_bit = 1'b0;
    else if (r_idx <= IDX_W'(8))
      w_bit = r_data[0];
    else if (r_idx == IDX_W'(9))
      w_bit = r_parity;
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_play_d1 <= 1'b0;
      r_play_d2 <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_play_d1 <= play;
      r_play_d2 <= r_play_d1;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_parity  <= w_parity_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_parity_nxt = r_parity;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_play_edge) begin
          if (bus.tape_len == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = '0;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_data_nxt   = bus.tape_data;
        w_parity_nxt = ~^bus.tape_data;
        w_idx_nxt    = '0;
        w_cnt_nxt    = CNT_ONE;
        w_state_nxt  = S_HIGH;
      end
      S_HIGH: begin
        if (w_tc) begin
          w_cnt_nxt   = w_bit ? CNT_ONE : CNT_ZERO;
          w_state_nxt = S_LOW;
        end else if (w_run) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (w_tc) begin
          if (r_idx == LAST_IDX) begin
            if (w_last_byte) begin
              w_state_nxt = S_DONE;
            end else begin
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_state_nxt = S_FETCH;
            end
          end else begin
            if (r_idx >= IDX_W'(1) && r_idx <= IDX_W'(8))
              w_data_nxt = r_data >> 1;
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = S_HIGH;
          end
        end else if (w_run) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // stop beats everything, including a play edge seen in the same cycle
    if (stop)
      w_state_nxt = S_IDLE;
  end

  assign bus.tape_addr = r_addr;
  assign bus.tape_rd   = (r_state == S_FETCH);
  assign K7_TAPEIN     = (r_state == S_HIGH);
  assign busy          = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                         (r_state == S_HIGH)  || (r_state == S_LOW);
  assign done          = (r_state == S_DONE);
endmodule
